wb_stream_sink: RTL and testbench

- Receiving end of the write-back output port: accepts the 512-bit result beats (data plus single-cycle valid, no backpressure) and the end-of-operation pulse from the write-back controller.
- Buffers beats in a FIFO and re-emits them on a ready/valid stream toward the DMA/host writer.
- Derives the frame-end marker (last) from the end-of-operation pulse, which arrives after the final beat.
- Holds back the newest beat until it is known whether that beat is the last one.

---
 rtl/wb_stream_sink_if.sv | 21 ++
 rtl/wb_stream_sink.sv | 106 ++++++++++
 tb/tb_wb_stream_sink.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/wb_stream_sink_if.sv
// Write-back beat input and ready/valid output stream of the write-back sink.
interface wb_stream_sink_if #(parameter int DATA_W = 512);
  logic              in_start_init;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_end_op;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tvalid;
  logic              m_tready;
  logic              m_tlast;

  modport slave (
    input  in_start_init, in_data, in_valid, in_end_op, m_tready,
    output m_tdata, m_tvalid, m_tlast
  );

  modport master (
    output in_start_init, in_data, in_valid, in_end_op, m_tready,
    input  m_tdata, m_tvalid, m_tlast
  );
endinterface

// File: rtl/wb_stream_sink.sv
// Write-back sink: buffers result beats in a register FIFO and re-emits them as a
// ready/valid stream, deriving last from the end-of-operation pulse.
module wb_stream_sink #(
  parameter int DATA_W     = 512,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  wb_stream_sink_if.slave   s,
  output logic              frame_done,
  output logic [CNT_W-1:0]  beat_count,
  output logic [ADDR_W:0]   fifo_level,
  output logic [1:0]        err
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [ADDR_W:0]     level_q, level_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          err_q, err_d;

  logic full, accepting, push_req, push, pop, drop_ovf, drop_late, init_clr;

  // Until end_op is seen the newest beat might still be the last, so it is withheld.
  always_comb begin
    s.m_tvalid = 1'b0;
    s.m_tlast  = 1'b0;
    case (state_q)
      RUN:     s.m_tvalid = (level_q >= (ADDR_W+1)'(2));
      DRAIN: begin
        s.m_tvalid = (level_q != '0);
        s.m_tlast  = (level_q == (ADDR_W+1)'(1));
      end
      default: ;
    endcase
  end

  assign s.m_tdata  = mem_q[rd_q];
  assign full       = (level_q == (ADDR_W+1)'(FIFO_DEPTH));
  assign accepting  = (state_q == IDLE) || (state_q == RUN);
  assign pop        = s.m_tvalid && s.m_tready;
  assign push_req   = s.in_valid && accepting;
  assign push       = push_req && (!full || pop);
  assign drop_ovf   = push_req && full && !pop;
  assign drop_late  = s.in_valid && !accepting;
  assign init_clr   = s.in_start_init && (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    wr_d    = push ? wr_q + ADDR_W'(1) : wr_q;
    rd_d    = pop  ? rd_q + ADDR_W'(1) : rd_q;
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + (ADDR_W+1)'(1);
      2'b01:   level_d = level_q - (ADDR_W+1)'(1);
      default: ;
    endcase
    cnt_d = init_clr ? '0 : cnt_q;
    err_d = init_clr ? '0 : err_q;
    if (push && !(&cnt_d)) cnt_d = cnt_d + CNT_W'(1);
    if (drop_ovf)  err_d[0] = 1'b1;
    if (drop_late) err_d[1] = 1'b1;
    case (state_q)
      IDLE: begin
        if (s.in_valid && s.in_end_op) state_d = DRAIN;
        else if (s.in_valid)           state_d = RUN;
        else if (s.in_end_op)          state_d = DONE;
      end
      RUN:     if (s.in_end_op) state_d = DRAIN;
      DRAIN:   if (pop && s.m_tlast) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= s.in_data;
  end

  assign frame_done = (state_q == DONE);
  assign beat_count = cnt_q;
  assign fifo_level = level_q;
  assign err        = err_q;
endmodule

// File: tb/tb_wb_stream_sink.sv
// Randomized bench for wb_stream_sink against a queue-based frame model.
module tb_wb_stream_sink;
  localparam int DW = 512;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic        frame_done;
  logic [15:0] beat_count;
  logic [4:0]  fifo_level;
  logic [1:0]  err;

  wb_stream_sink_if #(.DATA_W(DW)) ifc ();

  wb_stream_sink #(.DATA_W(DW), .FIFO_DEPTH(16), .ADDR_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .s(ifc),
    .frame_done(frame_done), .beat_count(beat_count),
    .fifo_level(fifo_level), .err(err)
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0;

  // mode: 0 idle, 1 collecting, 2 end seen (draining), 3 done pulse
  logic [DW-1:0] mq[$];
  int            mmode;
  logic [15:0]   mcnt;
  logic [1:0]    merr;

  task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] r;
    for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    mq.delete();
    mmode = 0;
    mcnt  = '0;
    merr  = '0;
  endtask

  // Compare outputs mid-cycle, then advance the model by the upcoming edge.
  task automatic step();
    logic etv, etl;
    bit   pop;
    int   sz, nmode;
    @(negedge clk);
    sz  = mq.size();
    etv = (mmode == 1) ? (sz >= 2) : (mmode == 2) ? (sz >= 1) : 1'b0;
    etl = (mmode == 2) && (sz == 1);
    chk("tvalid", ifc.m_tvalid, etv);
    chk("tlast", ifc.m_tlast, etl);
    chk("frame_done", frame_done, mmode == 3);
    chk("level", fifo_level, sz);
    chk("beat_count", beat_count, mcnt);
    chk("err", err, merr);
    if (etv) chk("tdata", ifc.m_tdata, mq[0]);

    if (mmode == 0 && ifc.in_start_init) begin mcnt = '0; merr = '0; end
    nmode = mmode;
    pop = etv && ifc.m_tready;
    if (pop) begin
      void'(mq.pop_front());
      if (etl) nmode = 3;
    end
    if (ifc.in_valid) begin
      if (mmode <= 1) begin
        if (sz == 16 && !pop) merr[0] = 1'b1;
        else begin
          mq.push_back(ifc.in_data);
          if (mcnt != 16'hffff) mcnt++;
        end
      end else merr[1] = 1'b1;
    end
    case (mmode)
      0: if (ifc.in_valid && ifc.in_end_op) nmode = 2;
         else if (ifc.in_valid) nmode = 1;
         else if (ifc.in_end_op) nmode = 3;
      1: if (ifc.in_end_op) nmode = 2;
      3: nmode = 0;
      default: ;
    endcase
    mmode = nmode;
    @(posedge clk); #1;
  endtask

  task automatic drv(bit v, logic [DW-1:0] d, bit eo, bit si, bit rdy);
    ifc.in_valid = v; ifc.in_data = d; ifc.in_end_op = eo;
    ifc.in_start_init = si; ifc.m_tready = rdy;
    step();
    ifc.in_valid = 1'b0; ifc.in_end_op = 1'b0; ifc.in_start_init = 1'b0;
  endtask

  task automatic idle(int n, bit rdy);
    for (int i = 0; i < n; i++) drv(1'b0, '0, 1'b0, 1'b0, rdy);
  endtask

  initial begin
    ifc.in_valid = 1'b0; ifc.in_data = '0; ifc.in_end_op = 1'b0;
    ifc.in_start_init = 1'b0; ifc.m_tready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tvalid", ifc.m_tvalid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_err", err, 0);
    chk("rst_cnt", beat_count, 0);
    chk("rst_done", frame_done, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // A, B, C back to back; C withheld until end_op
    drv(1, 512'hA, 0, 0, 1);
    drv(1, 512'hB, 0, 0, 1);
    drv(1, 512'hC, 0, 0, 1);
    idle(3, 1);
    drv(0, '0, 1, 0, 1);
    idle(4, 1);
    chk("t1_cnt", beat_count, 3);

    // overflow with stalled output
    drv(0, '0, 0, 1, 0);
    for (int i = 1; i <= 17; i++) drv(1, DW'(i), 0, 0, 0);
    chk("t2_level", fifo_level, 16);
    chk("t2_err", err, 2'b01);
    chk("t2_tvalid", ifc.m_tvalid, 1);
    chk("t2_head", ifc.m_tdata, 1);
    drv(0, '0, 1, 0, 1);
    idle(20, 1);
    chk("t2_cnt", beat_count, 16);

    // push into full FIFO in the same cycle as a pop
    drv(0, '0, 0, 1, 0);
    chk("t3_clr", err, 0);
    for (int i = 0; i < 16; i++) drv(1, rnd(), 0, 0, 0);
    drv(1, rnd(), 0, 0, 1);
    chk("t3_level", fifo_level, 16);
    chk("t3_err", err, 0);
    drv(0, '0, 1, 0, 1);
    idle(20, 1);

    // empty frame
    drv(0, '0, 1, 0, 1);
    chk("t4_done", frame_done, 1);
    idle(3, 1);

    // late beat during drain, then clear
    drv(1, rnd(), 0, 0, 0);
    drv(0, '0, 1, 0, 0);
    drv(1, rnd(), 0, 0, 0);
    chk("t5_err", err, 2'b10);
    idle(4, 1);
    drv(0, '0, 0, 1, 1);
    chk("t5_clr_err", err, 0);
    chk("t5_clr_cnt", beat_count, 0);

    // async reset mid-frame
    for (int i = 0; i < 5; i++) drv(1, rnd(), 0, 0, 0);
    chk("t6_pre_tvalid", ifc.m_tvalid, 1);
    rst = 1'b1;
    #1;
    chk("t6_tvalid", ifc.m_tvalid, 0);
    chk("t6_level", fifo_level, 0);
    chk("t6_err", err, 0);
    model_reset();
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    drv(1, rnd(), 0, 0, 1);
    drv(1, rnd(), 0, 0, 1);
    drv(0, '0, 1, 0, 1);
    idle(4, 1);

    // random traffic
    for (int i = 0; i < 3000; i++)
      drv($urandom_range(0, 2) != 0, rnd(), $urandom_range(0, 19) == 0,
          $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7);
    idle(24, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
